// File: rtl/csa_accum_seq.sv
// Carry-save multi-operand accumulator with a chunked, multi-cycle final carry-propagate add.
// Optional per-frame beat counter (out_count) is enabled by defining CSA_ACCUM_CNT_EN.
module csa_accum_seq #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int CPA_CHUNK = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef CSA_ACCUM_CNT_EN
  output logic [CNT_WIDTH-1:0] out_count,
`endif
  output logic [ACC_WIDTH-1:0] out_data
);

  localparam int NCHUNK = ACC_WIDTH / CPA_CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {ST_ACCUM, ST_RESOLVE, ST_DONE} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [ACC_WIDTH-1:0] r_s;
  logic [ACC_WIDTH-1:0] r_c;
  logic [ACC_WIDTH-1:0] r_out_data;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_cy;

  logic [ACC_WIDTH-1:0] w_x;
  logic [ACC_WIDTH-1:0] w_b;
  logic [CPA_CHUNK-1:0] w_s_chunk;
  logic [CPA_CHUNK-1:0] w_b_chunk;
  logic [CPA_CHUNK:0]   w_chunk_sum;
  logic                 w_in_fire;
  logic                 w_out_fire;
  logic                 w_last_chunk;

  assign w_x          = ACC_WIDTH'(in_data);
  // Shifting drops the carry MSB, which gives the modulo-2^ACC_WIDTH wrap.
  assign w_b          = r_c << 1;
  assign w_in_fire    = in_valid && in_ready;
  assign w_out_fire   = out_valid && out_ready;
  assign w_last_chunk = (r_idx == IDX_W'(NCHUNK - 1));
  assign w_s_chunk    = r_s[r_idx*CPA_CHUNK +: CPA_CHUNK];
  assign w_b_chunk    = w_b[r_idx*CPA_CHUNK +: CPA_CHUNK];
  assign w_chunk_sum  = (CPA_CHUNK+1)'(w_s_chunk) + (CPA_CHUNK+1)'(w_b_chunk)
                      + (CPA_CHUNK+1)'(r_cy);
  assign out_data     = r_out_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_ACCUM:   if (w_in_fire && in_last) w_state_next = ST_RESOLVE;
      ST_RESOLVE: if (w_last_chunk) w_state_next = ST_DONE;
      ST_DONE:    if (out_ready) w_state_next = ST_ACCUM;
      default:    w_state_next = ST_ACCUM;
    endcase
  end

  // in_ready is gated by rst so the port reads 0 for the whole reset pulse.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_ACCUM: in_ready  = !rst;
      ST_DONE:  out_valid = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s        <= '0;
      r_c        <= '0;
      r_idx      <= '0;
      r_cy       <= 1'b0;
      r_out_data <= '0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_in_fire) begin
            r_s <= r_s ^ w_b ^ w_x;
            r_c <= (r_s & w_b) | (r_s & w_x) | (w_b & w_x);
            if (in_last) begin
              r_idx <= '0;
              r_cy  <= 1'b0;
            end
          end
        end
        ST_RESOLVE: begin
          r_out_data[r_idx*CPA_CHUNK +: CPA_CHUNK] <= w_chunk_sum[CPA_CHUNK-1:0];
          r_cy  <= w_chunk_sum[CPA_CHUNK];
          r_idx <= r_idx + 1'b1;
        end
        ST_DONE: begin
          if (w_out_fire) begin
            r_s   <= '0;
            r_c   <= '0;
            r_idx <= '0;
            r_cy  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CSA_ACCUM_CNT_EN
  logic [CNT_WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_out_fire) begin
      r_cnt <= '0;
    end else if (w_in_fire && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign out_count = r_cnt;
`endif

endmodule

// File: tb/tb_csa_accum_seq.sv
// Directed bench for csa_accum_seq: default instance plus a 16/16/8 instance for the wrap case.
// Expected sums come from a plain integer model pushed to a scoreboard queue at the last beat.
module tb_csa_accum_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_last, out_ready;
  logic [7:0]  in_data;
  logic        in_ready, out_valid;
  logic [15:0] out_data;

  logic        in2_valid, in2_last, out2_ready;
  logic [15:0] in2_data;
  logic        in2_ready, out2_valid;
  logic [15:0] out2_data;

`ifdef CSA_ACCUM_CNT_EN
  logic [15:0] out_count, out2_count;
`endif

  int tests = 0;
  int fails = 0;

  logic [15:0] exp_q[$];
  int          cnt_q[$];
  int          model_acc   = 0;
  int          model_beats = 0;

  always #5 clk = ~clk;

  csa_accum_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef CSA_ACCUM_CNT_EN
    .out_count(out_count),
`endif
    .out_data(out_data)
  );

  csa_accum_seq #(.WIDTH(16), .ACC_WIDTH(16), .CPA_CHUNK(8)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in2_valid), .in_ready(in2_ready), .in_data(in2_data), .in_last(in2_last),
    .out_valid(out2_valid), .out_ready(out2_ready),
`ifdef CSA_ACCUM_CNT_EN
    .out_count(out2_count),
`endif
    .out_data(out2_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [7:0] d, input logic last);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    check("beat_ready", {31'b0, in_ready}, 32'd1);
    step();
    model_acc += int'(d);
    model_beats++;
    if (last) begin
      exp_q.push_back(16'(model_acc));
      cnt_q.push_back(model_beats);
      model_acc   = 0;
      model_beats = 0;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    $display("[TB] beat data=0x%02h last=%0d", d, last);
  endtask

  task automatic bubble(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic wait_result(input string tag, input int exp_lat);
    int lat = 0;
    logic saw_ready = 1'b0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
      if (in_ready) saw_ready = 1'b1;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_in_ready_low"}, {31'b0, saw_ready}, 32'd0);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      check({tag, "_data"}, {16'b0, out_data}, {16'b0, exp_q.pop_front()});
`ifdef CSA_ACCUM_CNT_EN
      check({tag, "_count"}, {16'b0, out_count}, 32'(cnt_q[0]));
`endif
      void'(cnt_q.pop_front());
    end
    $display("[TB] result %s out_data=0x%04h latency=%0d", tag, out_data, lat);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_valid_cleared"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [15:0] held;
    logic [15:0] exp2;
    int lat2;
    rst = 1'b1;
    in_valid = 0; in_last = 0; in_data = '0; out_ready = 0;
    in2_valid = 0; in2_last = 0; in2_data = '0; out2_ready = 0;
    #1;
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_in_ready", {31'b0, in_ready}, 32'd0);
    check("reset_out_data", {16'b0, out_data}, 32'd0);
    step();
    step();
    rst = 1'b0;
    #1;
    check("release_in_ready", {31'b0, in_ready}, 32'd1);

    // Frame 1: three 0xFF beats.
    beat(8'hFF, 1'b0);
    beat(8'hFF, 1'b0);
    beat(8'hFF, 1'b1);
    check("f1_model_sum", {16'b0, exp_q[0]}, 32'h02FD);
    wait_result("f1", 4);
    handshake("f1");

    // Frame 2: bubbles between beats, plus an early out_ready pulse while resolving.
    beat(8'h10, 1'b0);
    bubble(1);
    beat(8'h20, 1'b0);
    bubble(2);
    beat(8'h30, 1'b1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("f2_early_ready_no_valid", {31'b0, out_valid}, 32'd0);
    wait_result("f2", 3);
    handshake("f2");

    // Frame 3: backpressure with in_valid pushing 0xAA into a busy block.
    beat(8'h07, 1'b0);
    beat(8'h09, 1'b1);
    wait_result("f3", 4);
    held = out_data;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    in_last  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("f3_hold_data", {16'b0, out_data}, {16'b0, held});
      check("f3_hold_valid", {31'b0, out_valid}, 32'd1);
      check("f3_hold_no_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    handshake("f3");
    beat(8'h05, 1'b1);
    wait_result("f4_single", 4);
    handshake("f4");

    // Reset during RESOLVE drops the frame entirely.
    beat(8'h33, 1'b1);
    void'(exp_q.pop_back());
    void'(cnt_q.pop_back());
    step();
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    check("midrst_out_data", {16'b0, out_data}, 32'd0);
    step();
    check("midrst_hold_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("midrst_release_ready", {31'b0, in_ready}, 32'd1);
    repeat (5) begin
      step();
      check("midrst_no_valid", {31'b0, out_valid}, 32'd0);
    end
    beat(8'h11, 1'b1);
    wait_result("f5_after_rst", 4);
    handshake("f5");

    // Wide instance: 0xFFFF + 0x0002 wraps to 0x0001, two-chunk resolve.
    exp2 = 16'(32'h0000_FFFF + 32'h0000_0002);
    in2_valid = 1'b1;
    in2_data  = 16'hFFFF;
    in2_last  = 1'b0;
    check("w_ready", {31'b0, in2_ready}, 32'd1);
    step();
    in2_data = 16'h0002;
    in2_last = 1'b1;
    step();
    in2_valid = 1'b0;
    in2_last  = 1'b0;
    lat2 = 0;
    while (!out2_valid && lat2 < 50) begin
      step();
      lat2++;
    end
    check("w_latency", 32'(lat2), 32'd2);
    check("w_data", {16'b0, out2_data}, {16'b0, exp2});
`ifdef CSA_ACCUM_CNT_EN
    check("w_count", {16'b0, out2_count}, 32'd2);
`endif
    $display("[TB] result wide out_data=0x%04h latency=%0d", out2_data, lat2);
    out2_ready = 1'b1;
    step();
    out2_ready = 1'b0;
    check("w_valid_cleared", {31'b0, out2_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
